// File: rtl/microtile_vec_sequencer_pkg.sv
// rtl/microtile_vec_sequencer_pkg.sv - shared types, defaults and CRC-8 step for the microtile vector sequencer
package microtile_seq_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_SETTLE = 2;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        FIN
    } seq_state_t;

    typedef struct packed {
        logic [7:0] stim;
        logic [7:0] exp;
        logic [7:0] mask;
    } vec_entry_t;

    // MSB-first CRC-8 over one byte, no reflection, no final xor
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/microtile_vec_sequencer_if.sv
// rtl/microtile_vec_sequencer_if.sv - harness/tile bundle for the sequencer (sig only with MTSEQ_SIGNATURE_EN)
interface microtile_vec_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_stim;
    logic [7:0]    wr_exp;
    logic [7:0]    wr_mask;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic [7:0]    tile_ui_in;
    logic [7:0]    tile_uo_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] first_fail;
`ifdef MTSEQ_SIGNATURE_EN
    logic [7:0]    sig;
`endif

    modport master (
`ifdef MTSEQ_SIGNATURE_EN
        input  sig,
`endif
        output wr_en, wr_addr, wr_stim, wr_exp, wr_mask,
        output start, len, abort, tile_uo_out,
        input  tile_ui_in, busy, done, pass, err_cnt, first_fail
    );

    modport slave (
`ifdef MTSEQ_SIGNATURE_EN
        output sig,
`endif
        input  wr_en, wr_addr, wr_stim, wr_exp, wr_mask,
        input  start, len, abort, tile_uo_out,
        output tile_ui_in, busy, done, pass, err_cnt, first_fail
    );

endinterface

// File: rtl/microtile_vec_sequencer_mem.sv
// rtl/microtile_vec_sequencer_mem.sv - DEPTH x 24-bit vector store, synchronous write, asynchronous read
module microtile_vec_mem
    import microtile_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  vec_entry_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output vec_entry_t    rd_data
);

    vec_entry_t mem [DEPTH];

    // Store contents survive reset; only the harness rewrites them
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/microtile_vec_sequencer.sv
// rtl/microtile_vec_sequencer.sv - on-chip vector self-test of one microtile; MTSEQ_SIGNATURE_EN adds CRC-8 signature output
module microtile_vec_sequencer
    import microtile_seq_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SETTLE = DEF_SETTLE,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic                      clk,
    input logic                      rst_n,
    microtile_vec_sequencer_if.slave bus
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t    state;
    logic [AW-1:0] idx;
    logic [AW:0]   n_vec;
    logic [SCW-1:0] settle_cnt;
    logic [7:0]    ui_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [AW:0]   err_q;
    logic [AW-1:0] first_fail_q;

    vec_entry_t    wr_entry;
    vec_entry_t    cur;
    logic          mismatch;
    logic          last_vec;
    logic [AW:0]   err_next;
    logic [AW:0]   len_clamped;
    logic          accept;

    assign wr_entry = '{stim: bus.wr_stim, exp: bus.wr_exp, mask: bus.wr_mask};

    microtile_vec_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .wr_en  (bus.wr_en && (state == IDLE)),
        .wr_addr(bus.wr_addr),
        .wr_data(wr_entry),
        .rd_addr(idx),
        .rd_data(cur)
    );

    // Abort has priority over start when both arrive in IDLE
    assign accept      = (state == IDLE) && bus.start && !bus.abort;
    assign len_clamped = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
    assign mismatch    = |((bus.tile_uo_out ^ cur.exp) & cur.mask);
    assign err_next    = err_q + (AW+1)'(mismatch);
    assign last_vec    = (({1'b0, idx}) + (AW+1)'(1)) >= n_vec;

    // Main sequencing FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            n_vec        <= '0;
            settle_cnt   <= '0;
            ui_q         <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            if ((state != IDLE) && bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                pass_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            n_vec        <= len_clamped;
                            idx          <= '0;
                            err_q        <= '0;
                            first_fail_q <= '0;
                            pass_q       <= 1'b0;
                            busy_q       <= 1'b1;
                            state        <= (len_clamped == '0) ? FIN : DRIVE;
                        end
                    end
                    DRIVE: begin
                        ui_q       <= cur.stim;
                        settle_cnt <= '0;
                        state      <= (SETTLE == 0) ? SAMPLE : WAIT;
                    end
                    WAIT: begin
                        if (settle_cnt == SCW'(SETTLE - 1)) begin
                            state <= SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        if (mismatch) begin
                            err_q <= err_next;
                            if (err_q == '0) begin
                                first_fail_q <= idx;
                            end
                        end
                        if (last_vec) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            pass_q <= (err_next == '0);
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= DRIVE;
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                        // An empty run reaches FIN still busy, so its done lands one cycle later
                        if (busy_q) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            pass_q <= (err_q == '0);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.tile_ui_in = ui_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.first_fail = first_fail_q;

`ifdef MTSEQ_SIGNATURE_EN
    logic [7:0] sig_q;

    // Signature folds in each masked sample; frozen outside runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= CRC8_INIT;
        end else if (accept) begin
            sig_q <= CRC8_INIT;
        end else if ((state == SAMPLE) && !bus.abort) begin
            sig_q <= crc8_step(sig_q, bus.tile_uo_out & cur.mask);
        end
    end

    assign bus.sig = sig_q;
`endif

endmodule

// File: tb/tb_microtile_vec_sequencer.sv
// tb/tb_microtile_vec_sequencer.sv - directed self-checking bench for microtile_vec_sequencer
module tb_microtile_vec_sequencer;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;
    localparam int AW     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    microtile_vec_sequencer_if #(.DEPTH(DEPTH)) bus ();

    microtile_vec_sequencer #(
        .DEPTH (DEPTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Tile model: inverter
    assign bus.tile_uo_out = ~bus.tile_ui_in;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_vec(input int a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[AW-1:0];
        bus.wr_stim = s;
        bus.wr_exp  = e;
        bus.wr_mask = m;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Pulse start; lat = edges until done is seen (start-accepting edge counts as 1), -1 on timeout
    task automatic run(input int l, output int lat, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = l[AW:0];
        lat       = -1;
        busy_cyc  = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    // Serial LFSR form of CRC-8 (poly 0x07, init 0xFF)
    function automatic logic [7:0] sw_crc(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ d[b];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    initial begin
        int lat;
        int bc;
        int dcnt;
        logic [7:0] exp_sig;

        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_stim = 8'h00;
        bus.wr_exp  = 8'h00;
        bus.wr_mask = 8'h00;
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.abort   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pass", bus.pass, 1'b0);
        check("rst_err", bus.err_cnt, 0);
        check("rst_ff", bus.first_fail, 0);
        check("rst_ui", bus.tile_ui_in, 8'h00);
`ifdef MTSEQ_SIGNATURE_EN
        check("rst_sig", bus.sig, 8'hFF);
`endif
        rst_n = 1'b1;

        // Scenario 1: four passing vectors
        for (int i = 0; i < 4; i++) write_vec(i, 8'(i), 8'(i) ^ 8'hFF, 8'hFF);
        run(4, lat, bc);
        check("s1_lat", lat, 17);
        check("s1_busy_cycles", bc, 16);
        check("s1_pass", bus.pass, 1'b1);
        check("s1_err", bus.err_cnt, 0);
        check("s1_ui", bus.tile_ui_in, 8'h03);
`ifdef MTSEQ_SIGNATURE_EN
        exp_sig = 8'hFF;
        exp_sig = sw_crc(exp_sig, 8'hFF);
        exp_sig = sw_crc(exp_sig, 8'hFE);
        exp_sig = sw_crc(exp_sig, 8'hFD);
        exp_sig = sw_crc(exp_sig, 8'hFC);
        check("s1_sig", bus.sig, exp_sig);
`endif
        @(negedge clk);
        check("s1_done_pulse", bus.done, 1'b0);
        check("s1_pass_held", bus.pass, 1'b1);

        // Scenario 2: failing vectors 2 and 3, then mask out vector 2
        write_vec(2, 8'h02, 8'h00, 8'hFF);
        write_vec(3, 8'h03, 8'h00, 8'hFF);
        run(4, lat, bc);
        check("s2a_lat", lat, 17);
        check("s2a_pass", bus.pass, 1'b0);
        check("s2a_err", bus.err_cnt, 2);
        check("s2a_ff", bus.first_fail, 2);
        write_vec(2, 8'h02, 8'h00, 8'h00);
        run(4, lat, bc);
        check("s2b_err", bus.err_cnt, 1);
        check("s2b_ff", bus.first_fail, 3);
        check("s2b_pass", bus.pass, 1'b0);
        write_vec(2, 8'h02, 8'hFD, 8'hFF);
        write_vec(3, 8'h03, 8'hFC, 8'hFF);

        // Scenario 3: empty run, then oversize length clamps to DEPTH
        run(0, lat, bc);
        check("s3_len0_lat", lat, 2);
        check("s3_len0_busy", bc, 1);
        check("s3_len0_pass", bus.pass, 1'b1);
        check("s3_len0_err", bus.err_cnt, 0);
        for (int i = 4; i < 16; i++) write_vec(i, 8'(i), (i == 9) ? 8'h00 : (8'(i) ^ 8'hFF), 8'hFF);
        run(31, lat, bc);
        check("s3_len31_lat", lat, 65);
        check("s3_len31_ui", bus.tile_ui_in, 8'h0F);
        check("s3_len31_err", bus.err_cnt, 1);
        check("s3_len31_ff", bus.first_fail, 9);
        write_vec(9, 8'h09, 8'hF6, 8'hFF);

        // Write and start in the same IDLE cycle: run sees the new entry
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_stim = 8'h5A;
        bus.wr_exp  = 8'hA5;
        bus.wr_mask = 8'hFF;
        bus.start   = 1'b1;
        bus.len     = 5'd1;
        @(posedge clk);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 2; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check("wrstart_lat", lat, 5);
        check("wrstart_ui", bus.tile_ui_in, 8'h5A);
        check("wrstart_pass", bus.pass, 1'b1);
        write_vec(0, 8'h00, 8'hFF, 8'hFF);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 5'd4;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("startabort_busy", bus.busy, 1'b0);

        // Scenario 4: abort in WAIT of vector 1, with writes/start while busy
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 5'd4;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (k == 2) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = '0;
                bus.wr_stim = 8'h55;
                bus.wr_exp  = 8'h00;
                bus.wr_mask = 8'hFF;
                bus.start   = 1'b1;
                bus.len     = 5'd1;
            end
        end
        check("s4_busy_before", bus.busy, 1'b1);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check("s4_busy_after", bus.busy, 1'b0);
        check("s4_pass_after", bus.pass, 1'b0);
        check("s4_ui_after", bus.tile_ui_in, 8'h01);
        dcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check("s4_no_done", dcnt, 0);
        run(1, lat, bc);
        check("s4_rerun_lat", lat, 5);
        check("s4_rerun_ui", bus.tile_ui_in, 8'h00);
        check("s4_rerun_pass", bus.pass, 1'b1);

        // Scenario 5: asynchronous reset in SAMPLE of vector 2
        write_vec(1, 8'h01, 8'h00, 8'hFF);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 5'd4;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("s5_pre_err", bus.err_cnt, 1);
        check("s5_pre_ff", bus.first_fail, 1);
        check("s5_pre_ui", bus.tile_ui_in, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_rst_busy", bus.busy, 1'b0);
        check("s5_rst_err", bus.err_cnt, 0);
        check("s5_rst_ff", bus.first_fail, 0);
        check("s5_rst_ui", bus.tile_ui_in, 8'h00);
`ifdef MTSEQ_SIGNATURE_EN
        check("s5_rst_sig", bus.sig, 8'hFF);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check("s5_idle_after", dcnt, 0);
        write_vec(1, 8'h01, 8'hFE, 8'hFF);
        run(4, lat, bc);
        check("s5_rerun_lat", lat, 17);
        check("s5_rerun_pass", bus.pass, 1'b1);
        check("s5_rerun_err", bus.err_cnt, 0);
        check("s5_rerun_ui", bus.tile_ui_in, 8'h03);
`ifdef MTSEQ_SIGNATURE_EN
        check("s5_rerun_sig", bus.sig, exp_sig);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
